// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to the keyboard through open-drain pull-low enables.
// Sequence: clock inhibit, request-to-send, 10 device-clocked bits, ACK check.
// A single cycle counter times the inhibit window and then the overall frame timeout.
module ps2_host_tx #(
    parameter int CLK_INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES     = 1000000,
    parameter int CNT_W              = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_tx_done,
    output logic       o_tx_err,
    output logic       o_busy,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam logic [CNT_W-1:0] C_INH_LAST = CNT_W'(CLK_INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       C_IDX_STOP = 4'd9;

    state_t           r_state;
    logic [2:0]       r_clk_sync;
    logic [1:0]       r_data_sync;
    logic [9:0]       r_frame;
    logic [3:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_err;
    logic             r_clk_oe;
    logic             r_data_oe;

    logic             w_fall;
    logic             w_dsync;
    logic             w_timeout;

    assign w_fall    = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_dsync   = r_data_sync[1];
    assign w_timeout = (r_cnt == C_TO_LAST);

    // ready/busy are plain decodes of the state register, so they cannot disagree with it
    assign o_tx_ready    = (r_state == S_IDLE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_tx_done     = r_done;
    assign o_tx_err      = r_err;
    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_data_oe;

    // Resynchronise the asynchronous PS/2 lines; presetting high avoids a false fall after reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
        end
    end

    // Transmit sequencer: inhibit, start bit, device-clocked shifting, ACK and timeout handling
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_frame   <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_tx_valid) begin
                        r_frame  <= {1'b1, ~^i_tx_data, i_tx_data};
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        r_clk_oe <= 1'b1;
                        r_state  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_cnt == C_INH_LAST) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b1;
                        r_cnt     <= '0;
                        r_idx     <= '0;
                        r_state   <= S_SEND;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SEND: begin
                    // timeout wins over a simultaneous clock fall
                    if (w_timeout) begin
                        r_data_oe <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_fall) begin
                            r_data_oe <= ~r_frame[r_idx];
                            r_idx     <= r_idx + 1'b1;
                            if (r_idx == C_IDX_STOP) begin
                                r_state <= S_ACK;
                            end
                        end
                    end
                end
                S_ACK: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_fall) begin
                            if (!w_dsync) begin
                                r_state <= S_WAIT_IDLE;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_clk_sync[1] && w_dsync) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the shared open-drain lines,
// collects the bits the host presents on each rising clock, and checks them against
// the byte/odd-parity/stop framing computed directly from the byte value.
module tb_ps2_host_tx;

    localparam int INH     = 8;
    localparam int TO      = 400;
    // 32-cycle device clock period keeps a full frame plus ACK inside the 400-cycle timeout
    localparam int HALF    = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       busy;
    logic       clk_oe;
    logic       data_oe;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    wire        ps2_clk_line  = ~(clk_oe | dev_clk_low);
    wire        ps2_data_line = ~(data_oe | dev_data_low);

    int vectors     = 0;
    int miscompares = 0;
    int n_done      = 0;
    int n_err       = 0;
    int n_both      = 0;

    ps2_host_tx #(
        .CLK_INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES    (TO),
        .CNT_W             (20)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tx_data    (tx_data),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .o_tx_done    (tx_done),
        .o_tx_err     (tx_err),
        .o_busy       (busy),
        .i_ps2_clk    (ps2_clk_line),
        .i_ps2_data   (ps2_data_line),
        .o_ps2_clk_oe (clk_oe),
        .o_ps2_data_oe(data_oe)
    );

    always #5 clk = ~clk;

    // pulse counters; values registered before the edge are what get counted
    always @(posedge clk) begin
        if (!rst) begin
            if (tx_done) n_done++;
            if (tx_err) n_err++;
            if (tx_done && tx_err) n_both++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // odd parity: the parity bit makes the total count of ones odd
    function automatic logic ref_parity(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Device side of one transfer. Measures the inhibit window, reads the start bit,
    // then generates n_clocks clock pulses, sampling data on each rising edge.
    task automatic device_frame(input int start_dly, input bit do_ack, input int n_clocks,
                                input bit hold, input logic [7:0] nxt,
                                output logic [9:0] bits, output int inh, output logic start_bit);
        int w = 0;
        bits = '0;
        inh = 0;
        start_bit = 1'b1;
        while (!clk_oe && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!clk_oe) begin
            check("clk_oe_wait", 32'(clk_oe), 32'd1);
            return;
        end
        if (hold) tx_data = nxt;
        else tx_valid = 1'b0;
        while (clk_oe && inh < 100) begin
            inh++;
            @(negedge clk);
        end
        start_bit = ps2_data_line;
        if (n_clocks == 0) return;
        repeat (start_dly) @(negedge clk);
        for (int k = 0; k < n_clocks; k++) begin
            if (k == 10 && do_ack) begin
                dev_data_low = 1'b1;
                repeat (4) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k < 10) bits[k] = ps2_data_line;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_end(input int d0, input int e0);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_done + n_err != d0 + e0) begin
                seen = 1'b1;
                break;
            end
        end
        check("end_wait", 32'(seen), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b, input logic [9:0] fb);
        check({tag, "_data"}, 32'(fb[7:0]), 32'(b));
        check({tag, "_parity"}, 32'(fb[8]), 32'(ref_parity(b)));
        check({tag, "_stop"}, 32'(fb[9]), 32'd1);
    endtask

    task automatic send_and_check(input string tag, input logic [7:0] b, input int dly, input bit ack);
        logic [9:0] fb;
        int         ih;
        logic       sb;
        int         d0;
        int         e0;
        d0 = n_done;
        e0 = n_err;
        tx_data  = b;
        tx_valid = 1'b1;
        device_frame(dly, ack, 11, 1'b0, 8'h00, fb, ih, sb);
        check({tag, "_inhibit"}, 32'(ih), 32'(INH));
        check({tag, "_start"}, 32'(sb), 32'd0);
        check_frame(tag, b, fb);
        wait_end(d0, e0);
        repeat (2) @(negedge clk);
        check({tag, "_done_cnt"}, 32'(n_done - d0), ack ? 32'd1 : 32'd0);
        check({tag, "_err_cnt"}, 32'(n_err - e0), ack ? 32'd0 : 32'd1);
        check({tag, "_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_oe"}, {30'd0, clk_oe, data_oe}, 32'd0);
    endtask

    initial begin
        logic [9:0] fb;
        int         ih;
        logic       sb;
        int         d0;
        int         e0;
        int         n;
        logic [7:0] rb;

        rst      = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_oe", {30'd0, clk_oe, data_oe}, 32'd0);
        check("rst_pulses", {30'd0, tx_done, tx_err}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send_and_check("ed", 8'hED, 4, 1'b1);
        send_and_check("x00", 8'h00, 5, 1'b1);
        send_and_check("x01", 8'h01, 3, 1'b1);
        for (int r = 0; r < 5; r++) begin
            rb = 8'($urandom_range(0, 255));
            send_and_check("rnd", rb, int'($urandom_range(2, 8)), 1'b1);
        end

        // device clocks the whole frame but never pulls data low for the ACK
        send_and_check("noack", 8'($urandom_range(0, 255)), 4, 1'b0);
        check("noack_busy", 32'(busy), 32'd0);

        // device never clocks after the inhibit window
        d0 = n_done;
        e0 = n_err;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        device_frame(4, 1'b1, 0, 1'b0, 8'h00, fb, ih, sb);
        check("to_start", 32'(data_oe), 32'd1);
        n = 0;
        while (!tx_err && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", 32'(n), 32'(TO));
        check("to_data_oe", 32'(data_oe), 32'd0);
        repeat (2) @(negedge clk);
        check("to_err_cnt", 32'(n_err - e0), 32'd1);
        check("to_done_cnt", 32'(n_done - d0), 32'd0);
        check("to_idle", {30'd0, busy, clk_oe}, 32'd0);

        // valid held with a new byte during a transfer must not disturb it
        d0 = n_done;
        e0 = n_err;
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        device_frame(4, 1'b1, 11, 1'b1, 8'h55, fb, ih, sb);
        check("hold_inhibit", 32'(ih), 32'(INH));
        check_frame("hold_f4", 8'hF4, fb);
        wait_end(d0, e0);
        check("hold_done_cnt", 32'(n_done - d0), 32'd1);
        check("hold_next_busy", 32'(busy), 32'd1);
        d0 = n_done;
        e0 = n_err;
        device_frame(4, 1'b1, 11, 1'b0, 8'h00, fb, ih, sb);
        check_frame("hold_55", 8'h55, fb);
        wait_end(d0, e0);
        check("hold_55_done", 32'(n_done - d0), 32'd1);

        // reset in the middle of the data bits
        repeat (3) @(negedge clk);
        d0 = n_done;
        e0 = n_err;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        device_frame(4, 1'b1, 4, 1'b0, 8'h00, fb, ih, sb);
        check("mid_bits", 32'(fb[3:0]), 32'h0000000C);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_oe", {30'd0, clk_oe, data_oe}, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(tx_ready), 32'd1);
        check("mid_rst_pulse", {30'd0, tx_done, tx_err}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_cnts", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        send_and_check("ff", 8'hFF, 4, 1'b1);

        check("never_both", 32'(n_both), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
